// File: rtl/rng_pkg.sv
// Shared types and helpers for the bounded LFSR random source.
package rng_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   // Single tap bit for polynomial term x^n (bit n-1 of the state).
   function automatic logic [31:0] tap(input int unsigned n);
      return 32'd1 << (n - 1);
   endfunction

   // Maximal-length Fibonacci tap masks for widths 8..32.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      case (width)
         8:       return tap(8)  | tap(6)  | tap(5)  | tap(4);
         9:       return tap(9)  | tap(5);
         10:      return tap(10) | tap(7);
         11:      return tap(11) | tap(9);
         12:      return tap(12) | tap(6)  | tap(4)  | tap(1);
         13:      return tap(13) | tap(4)  | tap(3)  | tap(1);
         14:      return tap(14) | tap(5)  | tap(3)  | tap(1);
         15:      return tap(15) | tap(14);
         16:      return tap(16) | tap(15) | tap(13) | tap(4);
         17:      return tap(17) | tap(14);
         19:      return tap(19) | tap(6)  | tap(2)  | tap(1);
         20:      return tap(20) | tap(17);
         21:      return tap(21) | tap(19);
         22:      return tap(22) | tap(21);
         23:      return tap(23) | tap(18);
         24:      return tap(24) | tap(23) | tap(22) | tap(17);
         25:      return tap(25) | tap(22);
         26:      return tap(26) | tap(6)  | tap(2)  | tap(1);
         27:      return tap(27) | tap(5)  | tap(2)  | tap(1);
         28:      return tap(28) | tap(25);
         29:      return tap(29) | tap(27);
         30:      return tap(30) | tap(6)  | tap(4)  | tap(1);
         31:      return tap(31) | tap(28);
         32:      return tap(32) | tap(22) | tap(2)  | tap(1);
         default: return tap(18) | tap(11);
      endcase
   endfunction

   // All-ones mask covering every bit up to the highest set bit of value.
   function automatic logic [31:0] bitlen_mask(input logic [31:0] value);
      logic [31:0] m;
      m = value;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and step enable.
module lfsr_core
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned SEED  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] lfsr
);

   localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

   logic fb_c;

   assign fb_c = ^(lfsr & TAPS);

   // State update: reset, then seed load (zero maps to SEED), then step.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= SEED_W;
      end else if (load) begin
         lfsr <= (load_value == '0) ? SEED_W : load_value;
      end else if (step) begin
         lfsr <= {lfsr[WIDTH-2:0], fb_c};
      end
   end

endmodule

// File: rtl/rng_lfsr_ranged.sv
// Request/valid/ready random source bounded to an inclusive limit by rejection sampling.
module rng_lfsr_ranged
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH     = 18,
   parameter int unsigned SEED      = 1,
   parameter int unsigned MAX_TRIES = 16,
   parameter bit          FREE_RUN  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             change,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] random_value,
   output logic             rand_valid,
   input  logic             rand_ready,
   output logic             rand_fallback,
   output logic             overrun
);

   localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);
   localparam int unsigned W1    = WIDTH + 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   lfsr;
   logic [WIDTH-1:0]   lim_q, lim_d;
   logic [CNT_W-1:0]   try_cnt, try_d;
   logic [WIDTH-1:0]   value_d;
   logic               valid_d, fallback_d, overrun_d;
   logic               step_c;
   logic               accept_c, last_try_c;
   logic [WIDTH-1:0]   mask_c, masked_c, fb_value_c;
   logic [W1-1:0]      lim_p1_c, diff_c;

   lfsr_core #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .step       (step_c),
      .load       (seed_load),
      .load_value (seed_in),
      .lfsr       (lfsr)
   );

   // Candidate test and the deterministic fold used once tries run out.
   always_comb begin
      accept_c   = (lfsr <= lim_q);
      last_try_c = (try_cnt == CNT_W'(MAX_TRIES - 1));
      mask_c     = WIDTH'(bitlen_mask(32'(lim_q)));
      masked_c   = lfsr & mask_c;
      lim_p1_c   = {1'b0, lim_q} + W1'(1);
      diff_c     = {1'b0, masked_c} - lim_p1_c;
      fb_value_c = (masked_c > lim_q) ? WIDTH'(diff_c) : masked_c;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; seed load aborts any transaction.
   always_comb begin
      state_d = state_q;
      if (seed_load) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (change) state_d = SEARCH;
            SEARCH:  if (accept_c || last_try_c) state_d = PRESENT;
            PRESENT: if (rand_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output and datapath next values.
   always_comb begin
      step_c     = 1'b0;
      lim_d      = lim_q;
      try_d      = try_cnt;
      value_d    = random_value;
      valid_d    = rand_valid;
      fallback_d = rand_fallback;
      overrun_d  = overrun;
      if (seed_load) begin
         try_d      = '0;
         valid_d    = 1'b0;
         fallback_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (change) begin
                  step_c = 1'b1;
                  lim_d  = limit;
                  try_d  = '0;
               end else begin
                  step_c = FREE_RUN;
               end
            end
            SEARCH: begin
               if (change) overrun_d = 1'b1;
               if (accept_c) begin
                  value_d    = lfsr;
                  valid_d    = 1'b1;
                  fallback_d = 1'b0;
               end else if (last_try_c) begin
                  value_d    = fb_value_c;
                  valid_d    = 1'b1;
                  fallback_d = 1'b1;
               end else begin
                  step_c = 1'b1;
                  try_d  = try_cnt + CNT_W'(1);
               end
            end
            PRESENT: begin
               step_c = FREE_RUN;
               if (change)     overrun_d = 1'b1;
               if (rand_ready) valid_d   = 1'b0;
            end
            default: begin
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Registered outputs and captured request context.
   always_ff @(posedge clk) begin
      if (reset) begin
         lim_q         <= '0;
         try_cnt       <= '0;
         random_value  <= '0;
         rand_valid    <= 1'b0;
         rand_fallback <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         lim_q         <= lim_d;
         try_cnt       <= try_d;
         random_value  <= value_d;
         rand_valid    <= valid_d;
         rand_fallback <= fallback_d;
         overrun       <= overrun_d;
      end
   end

endmodule

// File: tb/tb_rng_lfsr_ranged.sv
// Scoreboard bench for rng_lfsr_ranged, plus a free-running instance.
module tb_rng_lfsr_ranged;

   localparam int unsigned W  = 18;
   localparam int unsigned MT = 16;
   localparam logic [W-1:0] TAPS18 = 18'h20400;
   localparam logic [W-1:0] ONES   = 18'h3FFFF;

   typedef struct {
      logic [W-1:0] value;
      logic         fb;
      int           lat;
      logic [W-1:0] lim;
   } want_t;

   logic         clk;
   logic         reset, change, seed_load, rand_ready;
   logic [W-1:0] seed_in, limit, random_value;
   logic         rand_valid, rand_fallback, overrun;

   logic         fr_reset, fr_change, fr_ready;
   logic [W-1:0] fr_value;
   logic         fr_valid, fr_fallback, fr_overrun;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] m_lfsr;
   want_t        sb[$];

   rng_lfsr_ranged #(.WIDTH(W), .SEED(1), .MAX_TRIES(MT), .FREE_RUN(1'b0)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .change        (change),
      .seed_load     (seed_load),
      .seed_in       (seed_in),
      .limit         (limit),
      .random_value  (random_value),
      .rand_valid    (rand_valid),
      .rand_ready    (rand_ready),
      .rand_fallback (rand_fallback),
      .overrun       (overrun)
   );

   rng_lfsr_ranged #(.WIDTH(W), .SEED(1), .MAX_TRIES(MT), .FREE_RUN(1'b1)) u_fr (
      .clk           (clk),
      .reset         (fr_reset),
      .change        (fr_change),
      .seed_load     (1'b0),
      .seed_in       (18'h0),
      .limit         (ONES),
      .random_value  (fr_value),
      .rand_valid    (fr_valid),
      .rand_ready    (fr_ready),
      .rand_fallback (fr_fallback),
      .overrun       (fr_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [W-1:0] m_step(input logic [W-1:0] x);
      return {x[W-2:0], ^(x & TAPS18)};
   endfunction

   // Reference request: rejection loop with fold fallback on the model LFSR.
   function automatic want_t model_request(input logic [W-1:0] lim);
      want_t        w;
      int           tries;
      bit           done;
      logic [W-1:0] msk, m;
      tries  = 0;
      done   = 0;
      m_lfsr = m_step(m_lfsr);
      while (!done) begin
         if (m_lfsr <= lim) begin
            w.value = m_lfsr;
            w.fb    = 1'b0;
            done    = 1;
         end else if (tries == MT - 1) begin
            msk = '0;
            for (int b = 0; b < W; b++)
               if (lim[b]) msk = (18'd1 << (b + 1)) - 18'd1;
            m       = m_lfsr & msk;
            w.value = (m > lim) ? (m - lim - 18'd1) : m;
            w.fb    = 1'b1;
            done    = 1;
         end else begin
            m_lfsr = m_step(m_lfsr);
            tries++;
         end
      end
      w.lat = tries + 2;
      w.lim = lim;
      return w;
   endfunction

   task automatic load_seed(input logic [W-1:0] s);
      seed_load = 1'b1;
      seed_in   = s;
      @(negedge clk);
      seed_load = 1'b0;
      seed_in   = '0;
      m_lfsr    = (s == '0) ? 18'd1 : s;
   endtask

   task automatic do_request(input logic [W-1:0] lim, input bit handshake,
                             output logic [W-1:0] val, output logic fb);
      want_t w, o;
      int    lat;
      change = 1'b1;
      limit  = lim;
      w = model_request(lim);
      sb.push_back(w);
      lat = 0;
      do begin
         @(negedge clk);
         change = 1'b0;
         limit  = W'($urandom);
         lat++;
      end while (!rand_valid && lat < 64);
      check_eq("valid_seen", 32'(rand_valid), 32'd1);
      o = sb.pop_front();
      check_eq("value", 32'(random_value), 32'(o.value));
      check_eq("fallback", 32'(rand_fallback), 32'(o.fb));
      check_eq("latency", 32'(lat), 32'(o.lat));
      check_eq("in_range", 32'(random_value <= o.lim), 32'd1);
      val = random_value;
      fb  = rand_fallback;
      if (handshake) begin
         rand_ready = 1'b1;
         @(negedge clk);
         rand_ready = 1'b0;
         check_eq("ready_clears", 32'(rand_valid), 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] v;
      logic         f;
      int           lat;
      logic [W-1:0] fm;

      reset = 1'b1; change = 1'b0; seed_load = 1'b0; seed_in = '0;
      limit = '0; rand_ready = 1'b0;
      fr_reset = 1'b1; fr_change = 1'b0; fr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_value", 32'(random_value), 32'd0);
      check_eq("rst_valid", 32'(rand_valid), 32'd0);
      check_eq("rst_fallback", 32'(rand_fallback), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      reset  = 1'b0;
      m_lfsr = 18'd1;
      @(negedge clk);

      // Walk from seed 1 with an always-accepting limit.
      load_seed(18'd1);
      do_request(ONES, 1'b1, v, f);
      check_eq("first_value", 32'(v), 32'h2);
      for (int i = 2; i <= 11; i++) do_request(ONES, 1'b1, v, f);
      check_eq("tap_feedback", 32'(v), 32'h801);

      // Small limits: forced fallback, zero limit, random mix.
      load_seed(18'h10);
      do_request(18'd3, 1'b1, v, f);
      check_eq("forced_fallback", 32'(f), 32'd1);
      load_seed(18'd1);
      do_request(18'd3, 1'b1, v, f);
      do_request(18'd0, 1'b1, v, f);
      check_eq("zero_limit", 32'(v), 32'd0);
      for (int i = 0; i < 8; i++)
         do_request(W'($urandom_range(1, 40)), 1'b1, v, f);
      for (int i = 0; i < 4; i++)
         do_request(W'($urandom_range(1000, 200000)), 1'b1, v, f);
      check_eq("overrun_clean", 32'(overrun), 32'd0);

      // Stall in PRESENT while change pulses; handshake with change high.
      do_request(ONES, 1'b0, v, f);
      for (int i = 0; i < 5; i++) begin
         change = 1'b1;
         @(negedge clk);
         change = 1'b0;
         check_eq("hold_value", 32'(random_value), 32'(v));
         check_eq("hold_valid", 32'(rand_valid), 32'd1);
      end
      check_eq("overrun_set", 32'(overrun), 32'd1);
      rand_ready = 1'b1;
      change     = 1'b1;
      @(negedge clk);
      rand_ready = 1'b0;
      change     = 1'b0;
      check_eq("hs_valid_low", 32'(rand_valid), 32'd0);
      repeat (4) @(negedge clk);
      check_eq("no_new_request", 32'(rand_valid), 32'd0);
      check_eq("overrun_sticky", 32'(overrun), 32'd1);
      do_request(ONES, 1'b1, v, f);

      // Seed load (zero -> SEED) aborts a long search.
      load_seed(18'h10);
      change = 1'b1;
      limit  = 18'd3;
      @(negedge clk);
      change = 1'b0;
      @(negedge clk);
      load_seed(18'd0);
      check_eq("abort_valid", 32'(rand_valid), 32'd0);
      repeat (20) @(negedge clk);
      check_eq("abort_dropped", 32'(rand_valid), 32'd0);
      do_request(ONES, 1'b1, v, f);
      check_eq("abort_reseed", 32'(v), 32'h2);

      // Reset while a result is presented.
      do_request(ONES, 1'b0, v, f);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("prst_value", 32'(random_value), 32'd0);
      check_eq("prst_valid", 32'(rand_valid), 32'd0);
      check_eq("prst_fallback", 32'(rand_fallback), 32'd0);
      check_eq("prst_overrun", 32'(overrun), 32'd0);
      m_lfsr = 18'd1;
      do_request(ONES, 1'b1, v, f);
      check_eq("prst_reseed", 32'(v), 32'h2);

      // Free-running build: LFSR steps on each idle cycle before the request.
      fr_reset = 1'b1;
      @(negedge clk);
      fr_reset = 1'b0;
      repeat (5) @(negedge clk);
      fr_change = 1'b1;
      fm = 18'd1;
      repeat (6) fm = m_step(fm);
      lat = 0;
      do begin
         @(negedge clk);
         fr_change = 1'b0;
         lat++;
      end while (!fr_valid && lat < 64);
      check_eq("fr_valid_seen", 32'(fr_valid), 32'd1);
      check_eq("fr_latency", 32'(lat), 32'd2);
      check_eq("fr_value", 32'(fr_value), 32'(fm));
      repeat (3) @(negedge clk);
      check_eq("fr_hold", 32'(fr_value), 32'(fm));
      check_eq("fr_fallback", 32'(fr_fallback), 32'd0);
      fr_ready = 1'b1;
      @(negedge clk);
      fr_ready = 1'b0;
      check_eq("fr_ready_clears", 32'(fr_valid), 32'd0);
      check_eq("fr_overrun", 32'(fr_overrun), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
